// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared types and helpers for the round-robin registered multiplexer.
//   mux_mode_t : channel selection policy (fixed select or round-robin)
//   next_ptr   : wraps a channel index to the following channel modulo n
// -----------------------------------------------------------------------------
package mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_t;

    // Index of the channel after k, wrapping to 0 past the last channel.
    function automatic int unsigned next_ptr(input int unsigned k, input int unsigned n);
        int unsigned r;
        if ((k + 32'd1) >= n) begin
            r = 32'd0;
        end else begin
            r = k + 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Picks at most one requesting channel, either the fixed channel sel or the
// first requester at or after the round-robin pointer. Owns the pointer.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   req        : per-channel request vector
//   en         : grant enable (output register can accept a word)
//   mode       : MODE_FIXED or MODE_RR
//   sel        : channel index used in MODE_FIXED (values >= N never grant)
//   gnt        : one-hot grant (all zero when nothing is granted)
//   idx        : binary index of the granted channel (0 when no grant)
// -----------------------------------------------------------------------------
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic            en,
    input  mux_mode_t       mode,
    input  logic [SELW-1:0] sel,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] idx
);

    logic [SELW-1:0] ptr_q;
    logic [SELW-1:0] ptr_d;
    logic            found_s;
    logic            hit_s;
    int              cand_s;

    // Grant selection: the search stops at the first hit so the grant stays one-hot.
    always_comb begin
        gnt     = '0;
        idx     = '0;
        found_s = 1'b0;
        hit_s   = 1'b0;
        cand_s  = 0;
        if (en) begin
            case (mode)
                MODE_FIXED: begin
                    for (int k = 0; k < N; k++) begin
                        hit_s   = !found_s && (sel == SELW'(k)) && req[k];
                        gnt[k]  = hit_s;
                        idx     = hit_s ? SELW'(k) : idx;
                        found_s = found_s || hit_s;
                    end
                end
                MODE_RR: begin
                    // Walk channels ptr, ptr+1, ... wrapping modulo N.
                    for (int i = 0; i < N; i++) begin
                        cand_s       = int'(ptr_q) + i;
                        cand_s       = (cand_s >= N) ? (cand_s - N) : cand_s;
                        hit_s        = !found_s && req[cand_s];
                        gnt[cand_s]  = hit_s;
                        idx          = hit_s ? SELW'(cand_s) : idx;
                        found_s      = found_s || hit_s;
                    end
                end
                default: begin
                    gnt = '0;
                    idx = '0;
                end
            endcase
        end else begin
            gnt = '0;
            idx = '0;
        end
    end

    // Pointer next state: only a round-robin grant moves it past the winner.
    always_comb begin
        ptr_d = ptr_q;
        if ((|gnt) && (mode == MODE_RR)) begin
            ptr_d = SELW'(next_ptr(32'(idx), 32'(N)));
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rr_mux_reg.sv
// -----------------------------------------------------------------------------
// rr_mux_reg
// N-input, WIDTH-bit multiplexer with a one-entry registered output and a
// valid/ready handshake per channel. A new word may load in the same cycle
// the held word drains, giving one word per cycle.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   mode       : 0 = fixed channel sel, 1 = round-robin among requesters
//   sel        : channel index for fixed mode
//   in_data    : channel k at bits [k*WIDTH +: WIDTH]
//   in_valid   : per-channel request
//   in_ready   : per-channel accept strobe (combinational, at most one high)
//   out_data   : registered selected word
//   out_chan   : registered index of the channel that produced out_data
//   out_valid  : output register holds a word
//   out_ready  : consumer accepts out_data this cycle
// -----------------------------------------------------------------------------
module rr_mux_reg
    import mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_chan,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] out_data_d;
    logic [SELW-1:0]  out_chan_q;
    logic [SELW-1:0]  out_chan_d;
    logic             out_valid_q;
    logic             out_valid_d;
    logic             grant_en_s;
    logic [N-1:0]     gnt_s;
    logic [SELW-1:0]  gnt_idx_s;

    // No grant during reset so nothing is accepted that will be discarded.
    assign grant_en_s = (!out_valid_q || out_ready) && !reset;

    rr_arbiter #(
        .N (N)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (in_valid),
        .en    (grant_en_s),
        .mode  (mux_mode_t'(mode)),
        .sel   (sel),
        .gnt   (gnt_s),
        .idx   (gnt_idx_s)
    );

    assign in_ready = gnt_s;

    // Output register next state: load on grant, else drain, else hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        if (|gnt_s) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[int'(gnt_idx_s)*WIDTH +: WIDTH];
            out_chan_d  = gnt_idx_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output register; reset drops any held word.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// -----------------------------------------------------------------------------
// tb_rr_mux_reg
// Directed bench for rr_mux_reg: a 4x32 instance and a 5x5 instance.
// -----------------------------------------------------------------------------
module tb_rr_mux_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        out_ready;

    // 4-channel, 32-bit instance
    logic        mode;
    logic [1:0]  sel;
    logic [127:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [31:0] out_data;
    logic [1:0]  out_chan;
    logic        out_valid;

    // 5-channel, 5-bit instance
    logic        mode5;
    logic [2:0]  sel5;
    logic [24:0] in_data5;
    logic [4:0]  in_valid5;
    logic [4:0]  in_ready5;
    logic [4:0]  out_data5;
    logic [2:0]  out_chan5;
    logic        out_valid5;

    int errors = 0;
    int checks = 0;

    logic [31:0] d  [4];
    logic [4:0]  d5 [5];
    int          exp_rr [5];
    int          exp_alt [4];

    always #5 clk = ~clk;

    rr_mux_reg #(.WIDTH(32), .N(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    rr_mux_reg #(.WIDTH(5), .N(5)) dut5 (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode5),
        .sel       (sel5),
        .in_data   (in_data5),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .out_data  (out_data5),
        .out_chan  (out_chan5),
        .out_valid (out_valid5),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        d[0] = 32'h1111_0000;
        d[1] = 32'h2222_0001;
        d[2] = 32'hDEAD_BEEF;
        d[3] = 32'h4444_0003;
        d5[0] = 5'h03; d5[1] = 5'h0C; d5[2] = 5'h15; d5[3] = 5'h1A; d5[4] = 5'h1F;
        exp_rr  = '{0, 1, 2, 3, 0};
        exp_alt = '{1, 3, 1, 3};

        reset     = 1'b1;
        out_ready = 1'b1;
        mode      = 1'b1;
        sel       = 2'd0;
        in_data   = {d[3], d[2], d[1], d[0]};
        in_valid  = 4'b1111;
        mode5     = 1'b0;
        sel5      = 3'd7;
        in_data5  = {d5[4], d5[3], d5[2], d5[1], d5[0]};
        in_valid5 = 5'b11111;

        // Reset held two cycles with all requests active
        tick();
        tick();
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_data", 64'(out_data), 64'd0);
        check("reset_chan", 64'(out_chan), 64'd0);
        check("reset_ready", 64'(in_ready), 64'd0);

        // Release: round-robin starts at channel 0
        reset = 1'b0;
        #1;
        check("rr_first_ready", 64'(in_ready), 64'b0001);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rr_all_chan", 64'(out_chan), 64'(exp_rr[i]));
            check("rr_all_data", 64'(out_data), 64'(d[exp_rr[i]]));
            check("rr_all_valid", 64'(out_valid), 64'd1);
        end

        // Sparse requesters 1 and 3 alternate (pointer now 1)
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_alt_chan", 64'(out_chan), 64'(exp_alt[i]));
        end

        // Load channel 1 so pointer becomes 2, then apply backpressure
        in_valid = 4'b0010;
        #1;
        check("bp_setup_ready", 64'(in_ready), 64'b0010);
        tick();
        check("bp_setup_chan", 64'(out_chan), 64'd1);
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready", 64'(in_ready), 64'd0);
            tick();
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_data", 64'(out_data), 64'(d[1]));
            check("bp_chan", 64'(out_chan), 64'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(in_ready), 64'b0100);
        tick();
        check("bp_release_chan", 64'(out_chan), 64'd2);
        check("bp_release_data", 64'(out_data), 64'(d[2]));

        // Reset while FULL and stalled
        out_ready = 1'b0;
        reset     = 1'b1;
        #1;
        check("midrst_ready", 64'(in_ready), 64'd0);
        tick();
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_data", 64'(out_data), 64'd0);
        reset = 1'b0;
        #1;
        check("midrst_ptr_ready", 64'(in_ready), 64'b0001);
        tick();
        check("midrst_chan", 64'(out_chan), 64'd0);
        check("midrst_valid2", 64'(out_valid), 64'd1);

        // Fixed mode, sel=2 (round-robin pointer is now 1)
        mode      = 1'b0;
        sel       = 2'd2;
        out_ready = 1'b1;
        #1;
        check("fix_ready", 64'(in_ready), 64'b0100);
        tick();
        check("fix_data", 64'(out_data), 64'h0000_0000_DEAD_BEEF);
        check("fix_chan", 64'(out_chan), 64'd2);
        in_valid = 4'b1011;
        #1;
        check("fix_noreq_ready", 64'(in_ready), 64'd0);
        tick();
        check("fix_drain_valid", 64'(out_valid), 64'd0);
        check("fix_drain_data", 64'(out_data), 64'h0000_0000_DEAD_BEEF);
        check("fix_drain_chan", 64'(out_chan), 64'd2);

        // Fixed grants left the round-robin pointer at 1
        mode     = 1'b1;
        in_valid = 4'b1111;
        #1;
        check("fix_ptr_kept", 64'(in_ready), 64'b0010);

        // Fixed-mode sweep over all channels
        mode = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sel = 2'(k);
            #1;
            check("sweep4_ready", 64'(in_ready), 64'(4'b0001 << k));
            tick();
            check("sweep4_data", 64'(out_data), 64'(d[k]));
            check("sweep4_chan", 64'(out_chan), 64'(k));
        end

        // 5-channel instance: out-of-range select never grants
        #1;
        check("n5_sel7_ready", 64'(in_ready5), 64'd0);
        check("n5_sel7_valid", 64'(out_valid5), 64'd0);
        for (int k = 0; k < 5; k++) begin
            sel5 = 3'(k);
            #1;
            check("sweep5_ready", 64'(in_ready5), 64'(5'b00001 << k));
            tick();
            check("sweep5_data", 64'(out_data5), 64'(d5[k]));
            check("sweep5_chan", 64'(out_chan5), 64'(k));
        end
        sel5 = 3'd7;
        #1;
        check("n5_sel7_ready2", 64'(in_ready5), 64'd0);
        tick();
        check("n5_sel7_drain", 64'(out_valid5), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
